// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// rst_seq_pkg : state encoding and saturating status-count helper | rev 1.0
// ============================================================================
package rst_seq_pkg;

  localparam int CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_debounce.sv
`default_nettype none
// ============================================================================
// rst_seq_debounce : 2-flop key_n synchronizer + stability debounce | rev 1.0
// ============================================================================
module rst_seq_debounce #(
  parameter int DEB_CYC = 1080000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic key_act_o
);

  localparam int DW = $clog2(DEB_CYC + 1);

  logic [1:0]    key_sync_q;
  logic          key_act_q;
  logic [DW-1:0] deb_cnt_q;
  logic          key_s;

  assign key_s     = key_sync_q[1];
  assign key_act_o = key_act_q;

  // The counter only runs while the synchronized key disagrees with the
  // debounced level; any return to agreement restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_q <= 2'b11;
      key_act_q  <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      key_sync_q <= {key_sync_q[0], key_n_i};
      if (~key_s == key_act_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DW'(DEB_CYC - 1)) begin
        key_act_q <= ~key_act_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// rst_seq : staged per-domain reset sequencer; RST_SEQ_DEBOUNCE_EN adds key debounce | rev 1.0
// ============================================================================
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_DOM      = 4,
  parameter int SETTLE_CYC = 1024,
  parameter int STAGE_CYC  = 64,
  parameter int DEB_CYC    = 1080000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             key_n,
  input  logic             soft_rst,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] rst_count
);

  localparam int MAXC = (SETTLE_CYC > STAGE_CYC) ? SETTLE_CYC : STAGE_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  if (N_DOM < 1 || N_DOM > 16 || SETTLE_CYC < 1 || STAGE_CYC < 1 || DEB_CYC < 1) begin : g_param_chk
    $error("rst_seq: parameter out of range");
  end

  logic [1:0]       lock_sync_q;
  logic             lock_s;
  logic             key_act;
  logic             abort;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_DOM-1:0] dom_q, dom_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;

`ifdef RST_SEQ_DEBOUNCE_EN
  rst_seq_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n_i   (key_n),
    .key_act_o (key_act)
  );
`else
  logic [1:0] key_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_sync_q <= 2'b11;
    else        key_sync_q <= {key_sync_q[0], key_n};
  end

  assign key_act = ~key_sync_q[1];
`endif

  assign lock_s = lock_sync_q[1];
  assign abort  = ~lock_s | key_act | soft_rst;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    dom_d     = dom_q;
    ready_d   = ready_q;
    rst_cnt_d = rst_cnt_q;
    if (state_q == ST_HOLD) begin
      cnt_d   = '0;
      dom_d   = '0;
      ready_d = 1'b0;
      if (!abort) state_d = ST_SETTLE;
    end else if (abort) begin
      state_d   = ST_HOLD;
      cnt_d     = '0;
      dom_d     = '0;
      ready_d   = 1'b0;
      rst_cnt_d = sat_inc(rst_cnt_q);
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            dom_d   = N_DOM'(1);
          end
        end
        ST_RELEASE: begin
          // dom_q is a thermometer code, so its top bit marks the last stage.
          if (cnt_q == CW'(STAGE_CYC - 1)) begin
            cnt_d = '0;
            if (dom_q[N_DOM-1]) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              dom_d = (dom_q << 1) | N_DOM'(1);
            end
          end
        end
        default: begin
          cnt_d   = cnt_q;
          dom_d   = '1;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= 2'b00;
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      dom_q       <= '0;
      ready_q     <= 1'b0;
      rst_cnt_q   <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dom_q       <= dom_d;
      ready_q     <= ready_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  assign dom_rst_n = dom_q;
  assign ready     = ready_q;
  assign state     = state_q;
  assign rst_count = rst_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
// tb_rst_seq : self-checking bench for rst_seq against an edge-time reference model | rev 1.0
// ============================================================================
module tb_rst_seq;

  localparam int N    = 3;
  localparam int S    = 8;
  localparam int ST   = 4;
  localparam int DEB  = 16;
  localparam int HMAX = 16384;

  logic         clk;
  logic         rst_n;
  logic         pll_locked;
  logic         key_n;
  logic         soft_rst;
  logic [N-1:0] dom_rst_n;
  logic         ready;
  logic [1:0]   state;
  logic [7:0]   rst_count;

  int tests = 0;
  int fails = 0;

  rst_seq #(
    .N_DOM      (N),
    .SETTLE_CYC (S),
    .STAGE_CYC  (ST),
    .DEB_CYC    (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .key_n      (key_n),
    .soft_rst   (soft_rst),
    .dom_rst_n  (dom_rst_n),
    .ready      (ready),
    .state      (state),
    .rst_count  (rst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw inputs recorded per edge; outputs derived from the
  // edge at which the current sequence started.
  bit           raw_lock_h [HMAX];
  bit           raw_key_h  [HMAX];
  int           ecnt;
  bit           m_active;
  int           m_start;
  int           m_cnt;
  bit           m_kact;
  int           m_last_flip;
  int           m_e;
  bit           m_abort;
  bit           m_flip;
  logic [N-1:0] exp_dom;
  logic         exp_ready;
  logic [1:0]   exp_state;
  logic [7:0]   exp_cnt;

  function automatic bit lock_at(int e);
    return (e >= 1 && e < HMAX) ? raw_lock_h[e] : 1'b0;
  endfunction

  function automatic bit keyn_at(int e);
    return (e >= 1 && e < HMAX) ? raw_key_h[e] : 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt = 0; m_active = 0; m_start = 0; m_cnt = 0; m_kact = 0; m_last_flip = 0;
      exp_dom = '0; exp_ready = 0; exp_state = 0; exp_cnt = 0;
    end else begin
      ecnt = ecnt + 1;
      if (ecnt < HMAX) begin
        raw_lock_h[ecnt] = pll_locked;
        raw_key_h[ecnt]  = key_n;
      end
      m_abort = !lock_at(ecnt - 2) || m_kact || soft_rst;
      if (m_active && m_abort) begin
        m_active = 0;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else if (!m_active && !m_abort) begin
        m_active = 1;
        m_start  = ecnt;
      end
`ifdef RST_SEQ_DEBOUNCE_EN
      if (ecnt - m_last_flip >= DEB) begin
        m_flip = 1;
        for (int j = 0; j < DEB; j++)
          if (!keyn_at(ecnt - 2 - j) == m_kact) m_flip = 0;
        if (m_flip) begin
          m_kact      = !m_kact;
          m_last_flip = ecnt;
        end
      end
`else
      m_kact = !keyn_at(ecnt - 1);
`endif
      exp_cnt = 8'(m_cnt);
      if (!m_active) begin
        exp_dom = '0; exp_ready = 0; exp_state = 2'd0;
      end else begin
        m_e       = ecnt - m_start;
        exp_state = (m_e < S) ? 2'd1 : (m_e < S + N * ST) ? 2'd2 : 2'd3;
        for (int i = 0; i < N; i++) exp_dom[i] = (m_e >= S + i * ST);
        exp_ready = (m_e >= S + N * ST);
      end
    end
  end

  task automatic test_reset();
    rst_n = 0; pll_locked = 0; key_n = 1; soft_rst = 0;
    repeat (3) @(negedge clk);
    tests++; if (dom_rst_n !== 3'b000) begin fails++; $display("FAIL reset_dom got %b want 000", dom_rst_n); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if (rst_count !== 8'd0) begin fails++; $display("FAIL reset_count got %0d want 0", rst_count); end
  endtask

  task automatic test_power_up();
    bit         chk;
    logic [2:0] w_dom;
    logic       w_rdy;
    @(negedge clk);
    pll_locked = 1; key_n = 1; soft_rst = 0; rst_n = 1;
    do begin
      @(negedge clk);
      tests++;
      if ({dom_rst_n, ready, state, rst_count} !== {exp_dom, exp_ready, exp_state, exp_cnt}) begin
        fails++;
        $display("FAIL pwr_model edge %0d got dom=%b rdy=%b st=%0d cnt=%0d want dom=%b rdy=%b st=%0d cnt=%0d",
                 ecnt, dom_rst_n, ready, state, rst_count, exp_dom, exp_ready, exp_state, exp_cnt);
      end
      chk = 1; w_dom = 3'b000; w_rdy = 0;
      case (ecnt)
        10: begin w_dom = 3'b000; w_rdy = 0; end
        11: begin w_dom = 3'b001; w_rdy = 0; end
        14: begin w_dom = 3'b001; w_rdy = 0; end
        15: begin w_dom = 3'b011; w_rdy = 0; end
        19: begin w_dom = 3'b111; w_rdy = 0; end
        22: begin w_dom = 3'b111; w_rdy = 0; end
        23: begin w_dom = 3'b111; w_rdy = 1; end
        default: chk = 0;
      endcase
      if (chk) begin
        tests++;
        if ({dom_rst_n, ready} !== {w_dom, w_rdy} || (ecnt == 23 && (state !== 2'd3 || rst_count !== 8'd0))) begin
          fails++;
          $display("FAIL pwr_timing edge %0d got dom=%b rdy=%b st=%0d cnt=%0d want dom=%b rdy=%b",
                   ecnt, dom_rst_n, ready, state, rst_count, w_dom, w_rdy);
        end
      end
    end while (ecnt < 30);
  endtask

  task automatic test_lock_loss();
    pll_locked = 0;
    while (ecnt < 80) begin
      if (ecnt == 40) pll_locked = 1;
      @(negedge clk);
      tests++;
      if ({dom_rst_n, ready, state, rst_count} !== {exp_dom, exp_ready, exp_state, exp_cnt}) begin
        fails++;
        $display("FAIL lock_model edge %0d got dom=%b rdy=%b st=%0d cnt=%0d want dom=%b rdy=%b st=%0d cnt=%0d",
                 ecnt, dom_rst_n, ready, state, rst_count, exp_dom, exp_ready, exp_state, exp_cnt);
      end
      if (ecnt == 32) begin
        tests++; if (state !== 2'd3) begin fails++; $display("FAIL lock_early st got %0d want 3", state); end
      end
      if (ecnt == 33) begin
        tests++;
        if ({dom_rst_n, ready, state, rst_count} !== {3'b000, 1'b0, 2'd0, 8'd1}) begin
          fails++; $display("FAIL lock_abort got dom=%b rdy=%b st=%0d cnt=%0d want 000/0/0/1", dom_rst_n, ready, state, rst_count);
        end
      end
      if (ecnt == 50 || ecnt == 51) begin
        tests++;
        if (dom_rst_n !== ((ecnt == 51) ? 3'b001 : 3'b000)) begin
          fails++; $display("FAIL lock_return edge %0d got dom=%b", ecnt, dom_rst_n);
        end
      end
    end
  endtask

  task automatic test_key_bounce();
    while (ecnt < 200) begin
      case (ecnt)
        80:  key_n = 0;
        90:  key_n = 1;
        120: key_n = 0;
        140: key_n = 1;
        default: ;
      endcase
      @(negedge clk);
      tests++;
      if ({dom_rst_n, ready, state, rst_count} !== {exp_dom, exp_ready, exp_state, exp_cnt}) begin
        fails++;
        $display("FAIL key_model edge %0d got dom=%b rdy=%b st=%0d cnt=%0d want dom=%b rdy=%b st=%0d cnt=%0d",
                 ecnt, dom_rst_n, ready, state, rst_count, exp_dom, exp_ready, exp_state, exp_cnt);
      end
`ifdef RST_SEQ_DEBOUNCE_EN
      if (ecnt == 100 || ecnt == 138) begin
        tests++; if (state !== 2'd3) begin fails++; $display("FAIL key_no_abort edge %0d st got %0d want 3", ecnt, state); end
      end
      if (ecnt == 139) begin
        tests++;
        if (state !== 2'd0 || rst_count !== 8'd2) begin
          fails++; $display("FAIL key_abort st got %0d cnt got %0d want 0/2", state, rst_count);
        end
      end
      if (ecnt == 158 || ecnt == 159) begin
        tests++;
        if (state !== ((ecnt == 159) ? 2'd1 : 2'd0)) begin
          fails++; $display("FAIL key_restart edge %0d st got %0d", ecnt, state);
        end
      end
`else
      if (ecnt == 82 || ecnt == 83) begin
        tests++;
        if (state !== ((ecnt == 83) ? 2'd0 : 2'd3)) begin
          fails++; $display("FAIL key_raw_abort edge %0d st got %0d", ecnt, state);
        end
      end
`endif
    end
  endtask

  task automatic test_soft_rst();
    int         n;
    logic [7:0] c0;
    soft_rst = 1;
    @(negedge clk);
    soft_rst = 0;
    n = 0;
    while (dom_rst_n !== 3'b001 && n < 60) begin @(negedge clk); n++; end
    tests++; if (dom_rst_n !== 3'b001) begin fails++; $display("FAIL soft_wait dom got %b want 001", dom_rst_n); end
    c0 = exp_cnt;
    soft_rst = 1;
    @(negedge clk);
    soft_rst = 0;
    tests++; if (dom_rst_n !== 3'b000) begin fails++; $display("FAIL soft_dom got %b want 000", dom_rst_n); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL soft_state got %0d want 0", state); end
    tests++; if (rst_count !== c0 + 8'd1) begin fails++; $display("FAIL soft_count got %0d want %0d", rst_count, c0 + 8'd1); end
    // Coincident lock loss and soft reset must count once.
    n = 0;
    while (state !== 2'd3 && n < 60) begin @(negedge clk); n++; end
    tests++; if (state !== 2'd3) begin fails++; $display("FAIL soft_wait_run st got %0d want 3", state); end
    c0 = exp_cnt;
    pll_locked = 0;
    repeat (2) @(negedge clk);
    soft_rst = 1;
    @(negedge clk);
    soft_rst = 0;
    tests++;
    if (state !== 2'd0 || rst_count !== c0 + 8'd1) begin
      fails++; $display("FAIL soft_coincide st=%0d cnt=%0d want 0/%0d", state, rst_count, c0 + 8'd1);
    end
    repeat (2) @(negedge clk);
    tests++; if (rst_count !== c0 + 8'd1) begin fails++; $display("FAIL soft_hold_cnt got %0d want %0d", rst_count, c0 + 8'd1); end
    pll_locked = 1;
  endtask

  task automatic test_saturation();
    int n;
    for (int p = 0; p < 300; p++) begin
      n = 0;
      while (state === 2'd0 && n < 20) begin @(negedge clk); n++; end
      soft_rst = 1;
      @(negedge clk);
      soft_rst = 0;
      tests++;
      if ({dom_rst_n, ready, state, rst_count} !== {exp_dom, exp_ready, exp_state, exp_cnt}) begin
        fails++;
        $display("FAIL sat_model pulse %0d got st=%0d cnt=%0d want st=%0d cnt=%0d", p, state, rst_count, exp_state, exp_cnt);
      end
    end
    tests++; if (rst_count !== 8'd255) begin fails++; $display("FAIL sat_final got %0d want 255", rst_count); end
  endtask

  task automatic test_random();
    int hold_left = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      tests++;
      if ({dom_rst_n, ready, state, rst_count} !== {exp_dom, exp_ready, exp_state, exp_cnt}) begin
        fails++;
        $display("FAIL rand_model edge %0d got dom=%b rdy=%b st=%0d cnt=%0d want dom=%b rdy=%b st=%0d cnt=%0d",
                 ecnt, dom_rst_n, ready, state, rst_count, exp_dom, exp_ready, exp_state, exp_cnt);
      end
      soft_rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 149) == 0) pll_locked = ~pll_locked;
      if (hold_left > 0) hold_left--;
      else if ($urandom_range(0, 99) == 0) hold_left = $urandom_range(1, 40);
      key_n = (hold_left == 0);
    end
    soft_rst = 0; pll_locked = 1; key_n = 1;
  endtask

  task automatic test_rst_mid_settle();
    int n = 0;
    while (state !== 2'd1 && n < 200) begin @(negedge clk); n++; end
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL mid_wait st got %0d want 1", state); end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    tests++; if (dom_rst_n !== 3'b000) begin fails++; $display("FAIL mid_dom got %b want 000", dom_rst_n); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL mid_state got %0d want 0", state); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_ready got %b want 0", ready); end
    tests++; if (rst_count !== 8'd0) begin fails++; $display("FAIL mid_count got %0d want 0", rst_count); end
    test_power_up();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss();
    test_key_bounce();
    test_soft_rst();
    test_saturation();
    test_random();
    test_rst_mid_settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
